des_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single shared DES core. It accepts encrypt/decrypt jobs (key, text, direction) from two independent requesters, typically the UART command path and a second on-chip client. For each job it latches the operands, pulses the core's start, waits for completion under a watchdog, and returns the result to the requester that owns the job. It sits between the requesters and the DES core and is the only driver of the core's inputs.

---
 rtl/des_arb_pkg.sv | 16 +
 rtl/des_arbiter_if.sv | 22 ++
 rtl/des_arb_wdt.sv | 29 ++
 rtl/des_arbiter.sv | 158 +++++++++++++++
 tb/tb_des_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/des_arb_pkg.sv
// Shared types and constants for the two-requester DES arbiter.
package des_arb_pkg;

  localparam int DES_W = 64;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/des_arbiter_if.sv
// Bus between the arbiter (master) and the shared DES core (slave).
interface des_arbiter_if;
  import des_arb_pkg::*;

  logic             DES_fStart;
  logic             DES_fDec;
  logic [DES_W-1:0] DES_Key;
  logic [DES_W-1:0] DES_Text;
  logic             DES_fDone;
  logic [DES_W-1:0] DES_Result;

  modport master (
    output DES_fStart, DES_fDec, DES_Key, DES_Text,
    input  DES_fDone, DES_Result
  );

  modport slave (
    input  DES_fStart, DES_fDec, DES_Key, DES_Text,
    output DES_fDone, DES_Result
  );

endinterface

// File: rtl/des_arb_wdt.sv
// Loadable up-counter; expire flags the cycle in which the count reaches TIMEOUT_CYC-1.
module des_arb_wdt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Looks at the incremented value so the abort lands exactly TIMEOUT_CYC cycles after START.
  assign expire = (int'(count_reg) + 1) >= (TIMEOUT_CYC - 1);

endmodule

// File: rtl/des_arbiter.sv
// Round-robin arbiter/sequencer sharing one DES core between two requesters.
module des_arbiter
  import des_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_fReq0,
  input  logic             i_fReq1,
  input  logic             i_fDec0,
  input  logic             i_fDec1,
  input  logic [DES_W-1:0] i_Key0,
  input  logic [DES_W-1:0] i_Key1,
  input  logic [DES_W-1:0] i_Text0,
  input  logic [DES_W-1:0] i_Text1,
  output logic             o_fAck0,
  output logic             o_fAck1,
  output logic             o_fDone0,
  output logic             o_fDone1,
  output logic [DES_W-1:0] o_Text,
  output logic             o_fErr,
  output logic             o_fBusy,
  des_arbiter_if.master    des
);

  arb_state_t       state_reg, state_next;
  logic             ptr_reg, ptr_next;
  logic             owner_reg, owner_next;
  logic             dec_reg, dec_next;
  logic [DES_W-1:0] key_reg, key_next;
  logic [DES_W-1:0] text_reg, text_next;
  logic [1:0]       ack_reg, ack_next;
  logic [DES_W-1:0] result_reg, result_next;
  logic             err_reg, err_next;

  logic [1:0]       req_vec;
  logic [1:0]       dec_vec;
  logic [DES_W-1:0] key_arr  [2];
  logic [DES_W-1:0] text_arr [2];
  logic [1:0]       done_vec;
  logic             gnt_idx;
  logic             wdt_clear;
  logic             wdt_en;
  logic             wdt_expire;

  assign req_vec     = {i_fReq1, i_fReq0};
  assign dec_vec     = {i_fDec1, i_fDec0};
  assign key_arr[0]  = i_Key0;
  assign key_arr[1]  = i_Key1;
  assign text_arr[0] = i_Text0;
  assign text_arr[1] = i_Text1;

  // On a tie the requester that was not served last wins; a lone request always wins.
  assign gnt_idx = (req_vec == 2'b11) ? ~ptr_reg : req_vec[1];

  des_arb_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .clear    (wdt_clear),
    .count_en (wdt_en),
    .expire   (wdt_expire)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= REQ1;
      owner_reg  <= REQ0;
      dec_reg    <= 1'b0;
      key_reg    <= '0;
      text_reg   <= '0;
      ack_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      owner_reg  <= owner_next;
      dec_reg    <= dec_next;
      key_reg    <= key_next;
      text_reg   <= text_next;
      ack_reg    <= ack_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    owner_next  = owner_reg;
    dec_next    = dec_reg;
    key_next    = key_reg;
    text_next   = text_reg;
    ack_next    = '0;
    result_next = result_reg;
    err_next    = err_reg;
    wdt_clear   = 1'b0;
    wdt_en      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req_vec) begin
          ptr_next          = gnt_idx;
          owner_next        = gnt_idx;
          dec_next          = dec_vec[gnt_idx];
          key_next          = key_arr[gnt_idx];
          text_next         = text_arr[gnt_idx];
          ack_next[gnt_idx] = 1'b1;
          state_next        = ST_START;
        end
      end
      ST_START: begin
        wdt_clear  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        wdt_en = 1'b1;
        // A completion in the expiry cycle still counts as a good result.
        if (des.DES_fDone) begin
          result_next = des.DES_Result;
          err_next    = 1'b0;
          state_next  = ST_DONE;
        end else if (wdt_expire) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_done
    assign done_vec[gi] = (state_reg == ST_DONE) && (owner_reg == 1'(gi));
  end

  assign o_fAck0  = ack_reg[REQ0];
  assign o_fAck1  = ack_reg[REQ1];
  assign o_fDone0 = done_vec[REQ0];
  assign o_fDone1 = done_vec[REQ1];
  assign o_Text   = result_reg;
  assign o_fErr   = err_reg;
  assign o_fBusy  = (state_reg != ST_IDLE);

  assign des.DES_fStart = (state_reg == ST_START);
  assign des.DES_fDec   = dec_reg;
  assign des.DES_Key    = key_reg;
  assign des.DES_Text   = text_reg;

endmodule

// File: tb/tb_des_arbiter.sv
// Directed bench: dut_a (default watchdog) for arbitration, dut_b (TIMEOUT_CYC=8) for the watchdog.
module tb_des_arbiter;
  import des_arb_pkg::*;

  localparam logic [63:0] K_KNOWN = 64'h133457799BBCDFF1;
  localparam logic [63:0] P_KNOWN = 64'h0123456789ABCDEF;
  localparam logic [63:0] C_KNOWN = 64'h85E813540F0AB405;
  localparam logic [63:0] K_ONE   = 64'h00000000FFFFFFFF;
  localparam logic [63:0] P_ONE   = 64'h1111111122222222;
  localparam logic [63:0] C_ONE   = 64'hEEEEEEEE22222222;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, req0_b = 1'b0;
  logic        dec0 = 1'b0, dec1 = 1'b0;
  logic [63:0] key0 = '0, key1 = '0, text0 = '0, text1 = '0;

  logic        ack0, ack1, done0, done1, err, busy;
  logic [63:0] otext;
  logic        ack0_b, ack1_b, done0_b, done1_b, err_b, busy_b;
  logic [63:0] otext_b;

  int   n_chk = 0;
  int   n_bad = 0;
  int   a_lat = 16, a_cnt = 0, a_starts = 0;
  int   b_lat = 0, b_cnt = 0;
  logic a_spur = 1'b0;

  des_arbiter_if bus_a ();
  des_arbiter_if bus_b ();

  always #5 clk = ~clk;

  des_arbiter dut_a (
    .i_Clk (clk), .i_Rst (rst),
    .i_fReq0 (req0), .i_fReq1 (req1), .i_fDec0 (dec0), .i_fDec1 (dec1),
    .i_Key0 (key0), .i_Key1 (key1), .i_Text0 (text0), .i_Text1 (text1),
    .o_fAck0 (ack0), .o_fAck1 (ack1), .o_fDone0 (done0), .o_fDone1 (done1),
    .o_Text (otext), .o_fErr (err), .o_fBusy (busy), .des (bus_a)
  );

  des_arbiter #(.TIMEOUT_CYC (8)) dut_b (
    .i_Clk (clk), .i_Rst (rst),
    .i_fReq0 (req0_b), .i_fReq1 (1'b0), .i_fDec0 (dec0), .i_fDec1 (dec1),
    .i_Key0 (key0), .i_Key1 (key1), .i_Text0 (text0), .i_Text1 (text1),
    .o_fAck0 (ack0_b), .o_fAck1 (ack1_b), .o_fDone0 (done0_b), .o_fDone1 (done1_b),
    .o_Text (otext_b), .o_fErr (err_b), .o_fBusy (busy_b), .des (bus_b)
  );

  // Stand-in core: known DES vector, otherwise an easy-to-hand-compute transform.
  function automatic logic [63:0] core_fn(input logic d, input logic [63:0] k, input logic [63:0] t);
    if (!d && k == K_KNOWN && t == P_KNOWN) return C_KNOWN;
    return k ^ t ^ {64{d}};
  endfunction

  // Latency L: DES_fDone is high L cycles after the start cycle; L < 2 means never.
  always @(posedge clk) begin
    bus_a.DES_fDone <= a_spur;
    if (bus_a.DES_fStart) begin
      a_starts         <= a_starts + 1;
      a_cnt            <= (a_lat >= 2) ? a_lat - 1 : 0;
      bus_a.DES_Result <= core_fn(bus_a.DES_fDec, bus_a.DES_Key, bus_a.DES_Text);
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) bus_a.DES_fDone <= 1'b1;
    end
  end

  always @(posedge clk) begin
    bus_b.DES_fDone <= 1'b0;
    if (bus_b.DES_fStart) begin
      b_cnt            <= (b_lat >= 2) ? b_lat - 1 : 0;
      bus_b.DES_Result <= core_fn(bus_b.DES_fDec, bus_b.DES_Key, bus_b.DES_Text);
    end else if (b_cnt > 0) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) bus_b.DES_fDone <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return done0;
      1:       return done1;
      default: return done0_b;
    endcase
  endfunction

  // Returns the number of cycles until the selected done pulse, or -1 after 60 cycles.
  task automatic wait_done(input int sel, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (pick(sel)) begin
        cyc = i;
        break;
      end
    end
    $display("job sel=%0d cycles=%0d text=%h err=%b", sel, cyc,
             (sel == 2) ? otext_b : otext, (sel == 2) ? err_b : err);
  endtask

  initial begin
    int c;
    int s0;
    int nd;

    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'({ack1, ack0}), 64'd0);
    check("rst_done", 64'({done1, done0}), 64'd0);
    check("rst_text", otext, 64'd0);
    check("rst_start", 64'(bus_a.DES_fStart), 64'd0);
    check("rst_key", bus_a.DES_Key, 64'd0);
    check("rst_dtext", bus_a.DES_Text, 64'd0);
    rst = 1'b0;
    tick();

    // single encrypt job on requester 0
    key0 = K_KNOWN; text0 = P_KNOWN; dec0 = 1'b0; req0 = 1'b1;
    key1 = K_ONE;   text1 = P_ONE;   dec1 = 1'b1;
    tick();
    check("t1_ack0", 64'(ack0), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_start", 64'(bus_a.DES_fStart), 64'd1);
    check("t1_key", bus_a.DES_Key, K_KNOWN);
    s0 = a_starts;
    req0 = 1'b0;
    wait_done(0, c);
    check("t1_lat", 64'(c), 64'd17);
    check("t1_text", otext, C_KNOWN);
    check("t1_err", 64'(err), 64'd0);
    check("t1_done1", 64'(done1), 64'd0);
    check("t1_starts", 64'(a_starts - s0), 64'd1);
    tick();
    check("t1_idle", 64'(busy), 64'd0);
    check("t1_hold", bus_a.DES_Key, K_KNOWN);

    // simultaneous requests from reset: 0, then 1, then 0 again
    rst = 1'b1;
    tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    check("t2_ack0", 64'({ack1, ack0}), 64'b01);
    req0 = 1'b0;
    wait_done(0, c);
    check("t2_lat0", 64'(c), 64'd17);
    check("t2_text0", otext, C_KNOWN);
    tick();
    check("t2_idle", 64'(busy), 64'd0);
    tick();
    check("t2_ack1", 64'({ack1, ack0}), 64'b10);
    check("t2_dec", 64'(bus_a.DES_fDec), 64'd1);
    req1 = 1'b0;
    wait_done(1, c);
    check("t2_lat1", 64'(c), 64'd17);
    check("t2_text1", otext, C_ONE);
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("t2_alt", 64'({ack1, ack0}), 64'b01);
    req0 = 1'b0; req1 = 1'b0;
    wait_done(0, c);
    check("t2_lat2", 64'(c), 64'd17);
    tick();

    // watchdog: core never answers
    b_lat = 0; req0_b = 1'b1;
    tick();
    check("t3_ack", 64'(ack0_b), 64'd1);
    req0_b = 1'b0;
    wait_done(2, c);
    check("t3_lat", 64'(c), 64'd8);
    check("t3_err", 64'(err_b), 64'd1);
    check("t3_text", otext_b, 64'd0);
    tick();
    check("t3_idle", 64'(busy_b), 64'd0);

    // core done exactly in the expiry cycle
    b_lat = 7; req0_b = 1'b1;
    tick();
    req0_b = 1'b0;
    wait_done(2, c);
    check("t4_lat", 64'(c), 64'd8);
    check("t4_err", 64'(err_b), 64'd0);
    check("t4_text", otext_b, C_KNOWN);
    tick();

    // reset in WAIT, late core done must be ignored
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_text", otext, 64'd0);
    check("t5_key", bus_a.DES_Key, 64'd0);
    nd = 0;
    repeat (20) begin
      tick();
      if (done0 || done1 || busy) nd++;
    end
    check("t5_quiet", 64'(nd), 64'd0);
    req0 = 1'b1;
    tick();
    check("t5_ack", 64'(ack0), 64'd1);
    req0 = 1'b0;
    wait_done(0, c);
    check("t5_lat", 64'(c), 64'd17);
    check("t5_res", otext, C_KNOWN);
    tick();

    // spurious core done in IDLE, then req1 held across DONE
    a_spur = 1'b1;
    tick();
    a_spur = 1'b0;
    nd = 0;
    repeat (3) begin
      tick();
      if (done0 || done1 || busy) nd++;
    end
    check("t6_spur", 64'(nd), 64'd0);
    req1 = 1'b1;
    tick();
    check("t6_ack1", 64'(ack1), 64'd1);
    wait_done(1, c);
    check("t6_lat", 64'(c), 64'd17);
    check("t6_text", otext, C_ONE);
    tick();
    check("t6_idle", 64'(busy), 64'd0);
    tick();
    check("t6_regrant", 64'(ack1), 64'd1);
    req1 = 1'b0;
    wait_done(1, c);
    check("t6_lat2", 64'(c), 64'd17);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
